// File: rtl/register_bank.sv
// 16 x 32 general-purpose register file with two combinational read ports,
// one synchronous write port, and write-through forwarding to both readers.
module register_bank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [ADDR_WIDTH-1:0] RA,
  input  logic [ADDR_WIDTH-1:0] RB,
  input  logic [ADDR_WIDTH-1:0] WC,
  input  logic [DATA_WIDTH-1:0] WPC,
  input  logic                  W_RB,
  output logic [DATA_WIDTH-1:0] PRA,
  output logic [DATA_WIDTH-1:0] PRB
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                  fwd_a;
  logic                  fwd_b;

  // Storage: async clear, write on rising edge when enabled.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (W_RB) begin
      regs_q[WC] <= WPC;
    end
  end

  // A same-cycle write to the read address is visible before the edge.
  always_comb begin
    fwd_a = RST_N && W_RB && (WC == RA);
    fwd_b = RST_N && W_RB && (WC == RB);
  end

  always_comb begin
    PRA = '0;
    PRB = '0;
    if (RST_N) begin
      PRA = fwd_a ? WPC : regs_q[RA];
      PRB = fwd_b ? WPC : regs_q[RB];
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: an array model checked every cycle plus
// literal expectations along the stimulus.
module tb_register_bank;

  logic        clk;
  logic        rst_n;
  logic [3:0]  ra, rb, wc;
  logic [31:0] wpc;
  logic        w_rb;
  logic [31:0] pra, prb;

  int checks;
  int failures;
  bit model_live;

  logic [31:0] mdl [16];

  register_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .CLK(clk), .RST_N(rst_n), .RA(ra), .RB(rb), .WC(wc),
    .WPC(wpc), .W_RB(w_rb), .PRA(pra), .PRB(prb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: register array cleared on reset, written on enabled edges.
  always @(negedge rst_n) begin
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1 && w_rb === 1'b1) mdl[wc] = wpc;
  end

  function automatic logic [31:0] expect_rd(input logic [3:0] a);
    if (rst_n !== 1'b1) return 32'h0;
    if (w_rb === 1'b1 && wc == a) return wpc;
    return mdl[a];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_live) begin
      check("model_pra", pra, expect_rd(ra));
      check("model_prb", prb, expect_rd(rb));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_live = 1'b0;
    ra = '0; rb = '0; wc = '0; wpc = '0; w_rb = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    model_live = 1'b1;
    #1;
    check("reset_low_pra", pra, 32'h0);
    check("reset_low_prb", prb, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Every address reads zero after reset on both ports.
    for (int a = 0; a < 16; a++) begin
      ra = 4'(a);
      rb = 4'(15 - a);
      #1;
      check("reset_read_a", pra, 32'h0);
      check("reset_read_b", prb, 32'h0);
    end
    tick();

    // Fill register k with k; forwarded value visible before the edge.
    w_rb = 1'b1;
    for (int k = 0; k < 16; k++) begin
      wc = 4'(k);
      wpc = 32'(k);
      ra = 4'(k);
      #1;
      check("fill_forward", pra, 32'(k));
      tick();
    end
    w_rb = 1'b0;
    for (int p = 0; p < 16; p += 2) begin
      ra = 4'(p);
      rb = 4'(p + 1);
      #1;
      check("readback_a", pra, 32'(p));
      check("readback_b", prb, 32'(p + 1));
    end
    tick();

    // Disabled write leaves register 5 alone.
    wc = 4'd5; wpc = 32'hDEADBEEF; ra = 4'd5; rb = 4'd4;
    repeat (3) tick();
    check("write_disable", pra, 32'h5);
    check("write_disable_other", prb, 32'h4);

    // Forwarding on port A, then the stored value matches.
    w_rb = 1'b1; wc = 4'd7; ra = 4'd7; rb = 4'd6; wpc = 32'hA5A5A5A5;
    #1;
    check("fwd_before_edge", pra, 32'hA5A5A5A5);
    check("fwd_other_port", prb, 32'h6);
    tick();
    w_rb = 1'b0;
    #1;
    check("fwd_after_edge", pra, 32'hA5A5A5A5);

    // Register 0 is writable; both ports on one address.
    w_rb = 1'b1; wc = 4'd0; wpc = 32'hFFFFFFFF;
    tick();
    w_rb = 1'b0; ra = 4'd0; rb = 4'd0;
    #1;
    check("reg0_a", pra, 32'hFFFFFFFF);
    check("reg0_b", prb, 32'hFFFFFFFF);

    // Last write wins.
    w_rb = 1'b1; wc = 4'd3; wpc = 32'h11111111;
    tick();
    wpc = 32'h22222222;
    tick();
    w_rb = 1'b0; ra = 4'd3;
    #1;
    check("last_write_wins", pra, 32'h22222222);
    tick();

    // Refill, then drop reset between edges.
    w_rb = 1'b1;
    for (int k = 0; k < 16; k++) begin
      wc = 4'(k);
      wpc = 32'h1000_0000 + 32'(k) * 32'h0101;
      tick();
    end
    w_rb = 1'b0; ra = 4'd9; rb = 4'd12;
    #1;
    check("refill_a", pra, 32'h1000_0909);
    check("refill_b", prb, 32'h1000_0C0C);
    rst_n = 1'b0;
    #1;
    check("async_reset_a", pra, 32'h0);
    check("async_reset_b", prb, 32'h0);
    // Write and forwarding are both suppressed while reset is low.
    w_rb = 1'b1; wc = 4'd9; wpc = 32'hCAFEF00D;
    #1;
    check("no_fwd_in_reset", pra, 32'h0);
    tick();
    w_rb = 1'b0;
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) begin
      ra = 4'(a);
      rb = 4'(a);
      #1;
      check("post_reset_a", pra, 32'h0);
      check("post_reset_b", prb, 32'h0);
    end
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
